segment_decoder_rx: RTL and testbench

- Receive-side counterpart of the switch-to-seven-segment display path.
- Samples a 7-bit segment bus, waits for the pattern to be stable, then decodes the glyph back to its 4-bit hex value.
- Delivers each new value once over a valid/ready handshake.
- Used as a loopback checker and monitor for the display encoder, and as the receiver when segment patterns cross between boards.

---
 rtl/segment_decoder_rx.sv | 175 +++++++++++++++++
 tb/tb_segment_decoder_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_decoder_rx.sv
// Purpose: seven-segment receiver; waits for a stable glyph on seg_in and decodes it to its hex value.
// Latency: a held pattern first sampled at edge k is offered after edge k+STABLE_CYCLES; all outputs registered.
// Backpressure: one value is held on num_out/out_valid until out_ready; seg_in keeps being sampled meanwhile.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   seg_in[6:0]  segment bus, bit0=a .. bit6=g, polarity set by ACTIVE_LOW
//   out_ready    consumer accepts num_out while out_valid is high
//   num_out[3:0] decoded hex value
//   out_valid    num_out holds a new, not yet accepted value
//   pattern_err  level: last stable pattern was neither a legal glyph nor blank
//   blank        level: last stable pattern had all segments off
module segment_decoder_rx #(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       out_ready,
    output logic [3:0] num_out,
    output logic       out_valid,
    output logic       pattern_err,
    output logic       blank
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OFFER  = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [6:0] seg_q;
    logic [6:0] seg_new;
    logic [7:0] stab_cnt;
    logic       stable;
    logic [6:0] last_reported, last_reported_n;
    logic       have_report, have_report_n;
    logic [3:0] num_n;
    logic       valid_n;
    logic       err_n;
    logic       blank_n;
    logic       glyph_legal;
    logic [3:0] glyph_val;

    // Everything downstream works on active-high gfedcba.
    assign seg_new = ACTIVE_LOW ? ~seg_in : seg_in;
    assign stable  = (stab_cnt == STABLE_MAX);

    // Glyph table for the registered sample.
    always_comb begin
        glyph_legal = 1'b1;
        glyph_val   = 4'h0;
        case (seg_q)
            7'h3F: glyph_val = 4'h0;
            7'h06: glyph_val = 4'h1;
            7'h5B: glyph_val = 4'h2;
            7'h4F: glyph_val = 4'h3;
            7'h66: glyph_val = 4'h4;
            7'h6D: glyph_val = 4'h5;
            7'h7D: glyph_val = 4'h6;
            7'h07: glyph_val = 4'h7;
            7'h7F: glyph_val = 4'h8;
            7'h6F: glyph_val = 4'h9;
            7'h77: glyph_val = 4'hA;
            7'h7C: glyph_val = 4'hB;
            7'h39: glyph_val = 4'hC;
            7'h5E: glyph_val = 4'hD;
            7'h79: glyph_val = 4'hE;
            7'h71: glyph_val = 4'hF;
            default: glyph_legal = 1'b0;
        endcase
    end

    // Sample register and run-length counter. The counter tracks how many
    // consecutive edges seg_q has held its current value.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q    <= 7'h00;
            stab_cnt <= 8'd0;
        end else begin
            seg_q <= seg_new;
            if (seg_new != seg_q) begin
                stab_cnt <= 8'd1;
            end else if (stab_cnt != STABLE_MAX) begin
                stab_cnt <= stab_cnt + 8'd1;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n         = state;
        num_n           = num_out;
        valid_n         = out_valid;
        err_n           = pattern_err;
        blank_n         = blank;
        last_reported_n = last_reported;
        have_report_n   = have_report;

        case (state)
            IDLE: begin
                if (!have_report || (seg_q != last_reported)) begin
                    state_n = SETTLE;
                end
            end

            SETTLE: begin
                // A changing pattern simply keeps the counter low; wait here.
                if (stable) begin
                    if (have_report && (seg_q == last_reported)) begin
                        // A glitch that settled back on the last pattern is not news.
                        state_n = IDLE;
                    end else begin
                        last_reported_n = seg_q;
                        have_report_n   = 1'b1;
                        if (seg_q == 7'h00) begin
                            blank_n = 1'b1;
                            err_n   = 1'b0;
                            state_n = IDLE;
                        end else if (glyph_legal) begin
                            num_n   = glyph_val;
                            valid_n = 1'b1;
                            err_n   = 1'b0;
                            blank_n = 1'b0;
                            state_n = OFFER;
                        end else begin
                            err_n   = 1'b1;
                            blank_n = 1'b0;
                            state_n = IDLE;
                        end
                    end
                end
            end

            OFFER: begin
                // num_out is frozen until accepted; seg_in activity is only counted.
                if (out_ready) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            num_out       <= 4'h0;
            out_valid     <= 1'b0;
            pattern_err   <= 1'b0;
            blank         <= 1'b0;
            last_reported <= 7'h00;
            have_report   <= 1'b0;
        end else begin
            state         <= state_n;
            num_out       <= num_n;
            out_valid     <= valid_n;
            pattern_err   <= err_n;
            blank         <= blank_n;
            last_reported <= last_reported_n;
            have_report   <= have_report_n;
        end
    end

endmodule

// File: tb/tb_segment_decoder_rx.sv
// Purpose: self-checking bench for segment_decoder_rx (directed scenarios plus randomized segment streams).
// Latency: checks exact offer latency after reset/pattern change and bounded latency after backpressure.
// Backpressure: out_ready held low in some scenarios to confirm num_out stays frozen.
module tb_segment_decoder_rx;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic       out_ready;
    logic [3:0] num_out;
    logic       out_valid;
    logic       pattern_err;
    logic       blank;

    int checks = 0;
    int errors = 0;

    logic [3:0] got_q[$];
    logic [3:0] exp_q[$];

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    segment_decoder_rx #(
        .STABLE_CYCLES(STABLE),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .out_ready  (out_ready),
        .num_out    (num_out),
        .out_valid  (out_valid),
        .pattern_err(pattern_err),
        .blank      (blank)
    );

    always #5 clk = ~clk;

    // Record every accepted transfer (valid and ready both high before the edge).
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back(num_out);
    end

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Patterns are given active-high; the bus itself is active-low.
    task automatic drive(input logic [6:0] p);
        seg_in = ~p;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!out_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_val%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    function automatic int lookup(input logic [6:0] p);
        int idx;
        idx = -1;
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == p) idx = i;
        end
        return idx;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1);
    end

    initial begin
        int n;
        logic [6:0] last_pat;
        logic [6:0] prev_pat;
        logic [6:0] p;
        int r;
        int dur;
        bit is_long;

        // 1: reset values, then exact first-report latency for glyph 3.
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(7'h4F);
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_num", num_out, 0);
        check("rst_err", pattern_err, 0);
        check("rst_blank", blank, 0);
        got_q.delete();
        rst = 1'b0;
        wait_valid(30, n);
        check("t1_latency", n, STABLE + 1);
        check("t1_num", num_out, 3);
        check("t1_err", pattern_err, 0);
        tick();
        check("t1_pulse", out_valid, 0);
        exp_q.delete();
        exp_q.push_back(4'h3);
        check_seq("t1_seq");

        // 2: a 2-cycle glimpse of "1" must not be reported, the held "4" must.
        got_q.delete();
        drive(7'h06);
        tick();
        tick();
        drive(7'h66);
        repeat (12) tick();
        exp_q.delete();
        exp_q.push_back(4'h4);
        check_seq("t2_seq");

        // 3: backpressure freezes "7" while the bus moves to "8".
        got_q.delete();
        out_ready = 1'b0;
        drive(7'h07);
        wait_valid(30, n);
        check("t3_latency", n, STABLE + 1);
        check("t3_num7", num_out, 7);
        drive(7'h7F);
        repeat (10) tick();
        check("t3_hold_valid", out_valid, 1);
        check("t3_hold_num", num_out, 7);
        out_ready = 1'b1;
        tick();
        check("t3_accept", out_valid, 0);
        wait_valid(30, n);
        check("t3_next_bound", (n <= STABLE) ? 1 : 0, 1);
        check("t3_num8", num_out, 8);
        tick();
        exp_q.delete();
        exp_q.push_back(4'h7);
        exp_q.push_back(4'h8);
        check_seq("t3_seq");

        // 4: blank in between lets the same glyph be reported again.
        got_q.delete();
        drive(7'h00);
        repeat (10) tick();
        check("t4_blank", blank, 1);
        check("t4_err", pattern_err, 0);
        check("t4_none", got_q.size(), 0);
        drive(7'h7F);
        repeat (10) tick();
        check("t4_unblank", blank, 0);
        exp_q.delete();
        exp_q.push_back(4'h8);
        check_seq("t4_seq");

        // 5: illegal pattern raises pattern_err only; a legal F clears it.
        got_q.delete();
        drive(7'h49);
        repeat (10) tick();
        check("t5_err", pattern_err, 1);
        check("t5_blank", blank, 0);
        check("t5_none", got_q.size(), 0);
        drive(7'h71);
        repeat (10) tick();
        check("t5_err_clr", pattern_err, 0);
        exp_q.delete();
        exp_q.push_back(4'hF);
        check_seq("t5_seq");

        // 6: reset during an offer drops it; the same pattern is reported afresh.
        got_q.delete();
        out_ready = 1'b0;
        drive(7'h77);
        wait_valid(30, n);
        check("t6_numA", num_out, 10);
        rst = 1'b1;
        tick();
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_num", num_out, 0);
        rst = 1'b0;
        wait_valid(30, n);
        check("t6_latency", n, STABLE + 1);
        check("t6_numA2", num_out, 10);
        out_ready = 1'b1;
        tick();
        exp_q.delete();
        exp_q.push_back(4'hA);
        check_seq("t6_seq");

        // Random stream of held patterns and short glitches, consumer always ready.
        // Expected: each held pattern that differs from the previous held pattern
        // is reported once; glitches alone never are.
        got_q.delete();
        exp_q.delete();
        last_pat = 7'h77;
        prev_pat = 7'h77;
        for (int s = 0; s < 60; s++) begin
            do begin
                r = $urandom_range(0, 9);
                if (r < 5)      p = glyph[$urandom_range(0, 15)];
                else if (r < 7) p = 7'h00;
                else            p = 7'($urandom_range(0, 127));
            end while (p == prev_pat);
            is_long = ($urandom_range(0, 2) != 0);
            dur = is_long ? $urandom_range(STABLE + 5, STABLE + 10)
                          : $urandom_range(1, STABLE - 1);
            drive(p);
            repeat (dur) tick();
            prev_pat = p;
            if (is_long) begin
                if (p != last_pat) begin
                    if (lookup(p) >= 0) exp_q.push_back(4'(lookup(p)));
                    last_pat = p;
                end
                check($sformatf("rnd%0d_blank", s), blank, (p == 7'h00) ? 1 : 0);
                check($sformatf("rnd%0d_err", s), pattern_err,
                      (p != 7'h00 && lookup(p) < 0) ? 1 : 0);
                check($sformatf("rnd%0d_idle", s), out_valid, 0);
            end
        end
        drive(prev_pat);
        repeat (STABLE + 6) tick();
        check_seq("rnd_seq");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
